// File: rtl/wb_data_ram_slave_if.sv
// Wishbone-classic bus bundle between the data-port initiator and the RAM responder.
// The request fields come from the master and the response fields come from the slave.
interface wb_data_ram_slave_if #(
    parameter int ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       wdat;
    logic [31:0]       rdat;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, sel, adr, wdat,
        input  rdat, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, wdat,
        output rdat, ack, err
    );
endinterface

// File: rtl/wb_data_ram_slave.sv
// Wishbone-classic responder backed by an on-chip word RAM, with WAIT_CYCLES wait states per access.
// Define WB_RAM_ERR_EN to end out-of-range requests with err; otherwise addresses alias and err stays 0.
//
// state  | meaning
// S_IDLE | waiting for a request
// S_WAIT | wait-state counter running
// S_RESP | ack or err high for exactly one cycle
module wb_data_ram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_W     = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    wb_data_ram_slave_if.slave  bus
);

    localparam int         DEPTH    = 1 << DEPTH_W;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_nx;
    logic [3:0]           cnt_q, cnt_nx;
    logic                 accept;
    logic                 enter_resp;

    logic                 we_q;
    logic [3:0]           sel_q;
    logic [DEPTH_W-1:0]   idx_q;
    logic [31:0]          dat_q;
    logic                 oor_q;
    logic [31:0]          rdat_q;

    logic                 in_oor;
    logic                 req_we;
    logic [3:0]           req_sel;
    logic [DEPTH_W-1:0]   req_idx;
    logic [31:0]          req_dat;
    logic                 req_oor;
    logic                 commit;
    logic                 rd_en;

    logic [31:0]          mem [DEPTH];

    logic                 unused_adr_bits;
    assign unused_adr_bits = ^bus.adr;

`ifdef WB_RAM_ERR_EN
    assign in_oor = (bus.adr >> (DEPTH_W + 2)) != '0;
`else
    assign in_oor = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state_q;
        cnt_nx     = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cyc && bus.stb) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx   = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // Abort has priority over the terminal count: a dropped cycle never commits.
                if (!bus.cyc) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt_q == '0) begin
                    state_nx   = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q  <= 1'b0;
            sel_q <= '0;
            idx_q <= '0;
            dat_q <= '0;
            oor_q <= 1'b0;
        end else if (accept) begin
            we_q  <= bus.we;
            sel_q <= bus.sel;
            idx_q <= bus.adr[DEPTH_W+1:2];
            dat_q <= bus.wdat;
            oor_q <= in_oor;
        end
    end

    // With zero wait states the access completes on the capture edge, so take the live bus fields.
    always_comb begin
        req_we  = we_q;
        req_sel = sel_q;
        req_idx = idx_q;
        req_dat = dat_q;
        req_oor = oor_q;
        if (state_q == S_IDLE) begin
            req_we  = bus.we;
            req_sel = bus.sel;
            req_idx = bus.adr[DEPTH_W+1:2];
            req_dat = bus.wdat;
            req_oor = in_oor;
        end
    end

    assign commit = i_rst_n && enter_resp && req_we && !req_oor;
    assign rd_en  = enter_resp && !req_we && !req_oor;

    always_ff @(posedge i_clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (req_sel[k]) begin
                    mem[req_idx][8*k +: 8] <= req_dat[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdat_q <= '0;
        end else begin
            rdat_q <= rd_en ? mem[req_idx] : '0;
        end
    end

    assign bus.rdat = rdat_q;
    assign bus.ack  = (state_q == S_RESP) && !oor_q;
    assign bus.err  = (state_q == S_RESP) && oor_q;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Bench for wb_data_ram_slave: a 2-wait-state instance driven from a vector table with a scoreboard,
// plus a 0-wait-state instance and hand sequences for abort, reset and request-capture corners.
module tb_wb_data_ram_slave;

    localparam int WAIT_A = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_data_ram_slave_if #(.ADDR_W(32)) bus_a ();
    wb_data_ram_slave_if #(.ADDR_W(32)) bus_z ();

    wb_data_ram_slave #(.ADDR_W(32), .DEPTH_W(10), .WAIT_CYCLES(WAIT_A)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    wb_data_ram_slave #(.ADDR_W(32), .DEPTH_W(10), .WAIT_CYCLES(0)) dut_z (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_z)
    );

    typedef struct {
        bit          we;
        bit [3:0]    sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp_dat;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        bit          chk_dat;
        bit          err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive_a(input bit we, input bit [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] wdat);
        bus_a.cyc  = 1'b1;
        bus_a.stb  = 1'b1;
        bus_a.we   = we;
        bus_a.sel  = sel;
        bus_a.adr  = adr;
        bus_a.wdat = wdat;
    endtask

    task automatic idle_a();
        bus_a.cyc = 1'b0;
        bus_a.stb = 1'b0;
        bus_a.we  = 1'b0;
    endtask

    task automatic txn_a(input bit we, input bit [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [31:0] exp_dat, input bit exp_err);
        exp_t e;
        bit   got;
        int   lat;
        int   k;
        sb.push_back('{exp_dat, (!we || exp_err), exp_err});
        @(negedge clk);
        drive_a(we, sel, adr, wdat);
        got = 1'b0;
        lat = 0;
        k   = 0;
        while (!got && k < 8) begin
            @(negedge clk);
            if (bus_a.ack || bus_a.err) begin
                got = 1'b1;
                lat = k;
            end
            k++;
        end
        e = sb.pop_front();
        chk("ack_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", 32'(lat), 32'(WAIT_A));
            chk("err_flag", 32'(bus_a.err), 32'(e.err));
            chk("ack_flag", 32'(bus_a.ack), 32'(!e.err));
            if (e.chk_dat) chk("rdat", bus_a.rdat, e.dat);
        end
        idle_a();
        @(negedge clk);
        chk("pulse_len", {30'd0, bus_a.ack, bus_a.err}, 32'd0);
        chk("rdat_clear", bus_a.rdat, 32'd0);
    endtask

    initial begin
        bus_a.cyc = 0; bus_a.stb = 0; bus_a.we = 0; bus_a.sel = 0; bus_a.adr = 0; bus_a.wdat = 0;
        bus_z.cyc = 0; bus_z.stb = 0; bus_z.we = 0; bus_z.sel = 0; bus_z.adr = 0; bus_z.wdat = 0;

        vecs.push_back('{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h20, 32'h0,        32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 4'h0, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'h0, 32'h22, 32'h0,        32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 32'h0,  32'h12345678, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 4'hF, 32'h4,  32'h00000000, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 4'hA, 32'h5,  32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h4,  32'h0,        32'hFF00FF00, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h0,  32'h0,        32'h12345678, 1'b0});
`ifdef WB_RAM_ERR_EN
        vecs.push_back('{1'b1, 4'hF, 32'h1000, 32'h00000099, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 4'hF, 32'h0,    32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h1004, 32'h0,        32'h0,        1'b1});
`else
        vecs.push_back('{1'b1, 4'hF, 32'h1000, 32'h00000099, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h0,    32'h0,        32'h00000099, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 32'h1004, 32'h0,        32'hFF00FF00, 1'b0});
`endif

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_a_outs", {30'd0, bus_a.ack, bus_a.err}, 32'd0);
        chk("rst_a_rdat", bus_a.rdat, 32'd0);
        chk("rst_z_outs", {30'd0, bus_z.ack, bus_z.err}, 32'd0);
        chk("rst_z_rdat", bus_z.rdat, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            txn_a(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].wdat, vecs[i].exp_dat, vecs[i].exp_err);
        end

        // Request fields change mid-wait, including we: the captured write must still land.
        @(negedge clk);
        drive_a(1'b1, 4'hF, 32'h50, 32'h0000600D);
        @(negedge clk);
        bus_a.adr = 32'h54; bus_a.wdat = 32'h00000BAD; bus_a.we = 1'b0; bus_a.sel = 4'h0;
        @(negedge clk);
        chk("hold_no_early_ack", 32'(bus_a.ack), 32'd0);
        @(negedge clk);
        chk("hold_ack", 32'(bus_a.ack), 32'd1);
        idle_a();
        txn_a(1'b0, 4'hF, 32'h50, 32'h0, 32'h0000600D, 1'b0);

        // Abort: cycle dropped after one wait state
        txn_a(1'b1, 4'hF, 32'h40, 32'h0BADC0DE, 32'h0, 1'b0);
        @(negedge clk);
        drive_a(1'b1, 4'hF, 32'h40, 32'h00000055);
        @(negedge clk);
        idle_a();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ack", {30'd0, bus_a.ack, bus_a.err}, 32'd0);
        end
        txn_a(1'b0, 4'hF, 32'h40, 32'h0, 32'h0BADC0DE, 1'b0);

        // Reset in the last wait cycle: no commit, no ack after release
        @(negedge clk);
        drive_a(1'b1, 4'hF, 32'h40, 32'h00000077);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstwait_outs", {30'd0, bus_a.ack, bus_a.err}, 32'd0);
        chk("rstwait_rdat", bus_a.rdat, 32'd0);
        idle_a();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstwait_no_ack", {30'd0, bus_a.ack, bus_a.err}, 32'd0);
        end
        txn_a(1'b0, 4'hF, 32'h40, 32'h0, 32'h0BADC0DE, 1'b0);

        // Reset during the ack cycle: ack drops at once, committed write survives
        @(negedge clk);
        drive_a(1'b1, 4'hF, 32'h60, 32'h1234ABCD);
        repeat (3) @(negedge clk);
        chk("rstresp_ack_before", 32'(bus_a.ack), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstresp_ack_drop", 32'(bus_a.ack), 32'd0);
        idle_a();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn_a(1'b0, 4'hF, 32'h60, 32'h0, 32'h1234ABCD, 1'b0);

        // Zero wait states: ack right after the sampling edge, held strobe alternates ack/idle
        @(negedge clk);
        bus_z.cyc = 1; bus_z.stb = 1; bus_z.we = 1; bus_z.sel = 4'hF;
        bus_z.adr = 32'h8; bus_z.wdat = 32'hA5A5A5A5;
        @(negedge clk);
        chk("z_write_ack", 32'(bus_z.ack), 32'd1);
        bus_z.cyc = 0; bus_z.stb = 0; bus_z.we = 0;
        @(negedge clk);
        chk("z_write_pulse", 32'(bus_z.ack), 32'd0);
        bus_z.cyc = 1; bus_z.stb = 1; bus_z.we = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("z_hold_ack", 32'(bus_z.ack), 32'((k % 2) == 0));
            chk("z_hold_rdat", bus_z.rdat, ((k % 2) == 0) ? 32'hA5A5A5A5 : 32'h0);
        end
        bus_z.cyc = 0; bus_z.stb = 0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
